intr_ctrl: RTL and testbench

- Interrupt controller for the jacaranda-8 core; the producer of the register-file bank select `intr_en`.
- Latches rising edges on external interrupt lines into pending bits and arbitrates them by fixed priority.
- At an instruction boundary it enters interrupt mode, redirects the PC to a vector and saves the return PC.
- It holds `intr_en` high until the handler executes `reti`, so the handler runs on the shadow register bank.

---
 rtl/jacaranda_pkg.sv | 20 ++
 rtl/intr_prio_enc.sv | 23 ++
 rtl/intr_ctrl.sv | 107 ++++++++++
 tb/tb_intr_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jacaranda_pkg.sv
// Shared definitions for the jacaranda-8 core: address width, interrupt
// vector defaults and the interrupt controller state encoding.
package jacaranda_pkg;

    localparam int unsigned ADDR_W = 8;

    localparam logic [ADDR_W-1:0] VEC_BASE_DEF   = 8'hE0;
    localparam logic [ADDR_W-1:0] VEC_STRIDE_DEF = 8'h04;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Index width for n request lines, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt lines.
// Outputs idx=0 when nothing is eligible.
module intr_prio_enc #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        any = |eligible;
        idx = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (eligible[i-1]) begin
                idx = ID_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, fixed-priority arbitration,
// single-level interrupt mode driving the shadow register bank select.
module intr_ctrl
    import jacaranda_pkg::*;
#(
    parameter int unsigned       NUM_IRQ    = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_IRQ-1:0]              irq,
    input  logic                            instr_done,
    input  logic [ADDR_W-1:0]               pc_in,
    input  logic                            reti,
    input  logic                            mask_we,
    input  logic [NUM_IRQ-1:0]              mask_wdata,
    output logic                            intr_en,
    output logic                            take_intr,
    output logic [ADDR_W-1:0]               intr_vector,
    output logic [ADDR_W-1:0]               ret_pc,
    output logic [id_width(NUM_IRQ)-1:0]    irq_id,
    output logic [NUM_IRQ-1:0]              pending
);

    localparam int unsigned ID_W = id_width(NUM_IRQ);

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic               any;
    logic [ID_W-1:0]    win;
    logic               take;

    assign rise     = irq & ~irq_prev;
    assign eligible = pending & mask;

    // intr_en is a decode of the state flop, so reset clears it asynchronously.
    assign intr_en = (state == ACTIVE);

    intr_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .eligible (eligible),
        .any      (any),
        .idx      (win)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        clr        = '0;
        case (state)
            IDLE: begin
                if (any && instr_done) begin
                    take       = 1'b1;
                    clr[win]   = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (reti) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_prev    <= '0;
            pending     <= '0;
            mask        <= '0;
            take_intr   <= 1'b0;
            intr_vector <= '0;
            ret_pc      <= '0;
            irq_id      <= '0;
        end else begin
            irq_prev  <= irq;
            // A rise on the line being taken keeps it pending.
            pending   <= (pending & ~clr) | rise;
            take_intr <= take;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (take) begin
                ret_pc      <= pc_in;
                irq_id      <= win;
                intr_vector <= VEC_BASE + ADDR_W'(win) * VEC_STRIDE;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: table-driven priority encoder vectors
// plus directed multi-cycle sequences for the controller.
module tb_intr_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq = '0;
    logic       instr_done = 1'b0;
    logic [7:0] pc_in = '0;
    logic       reti = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;

    logic       intr_en, take_intr;
    logic [7:0] intr_vector, ret_pc;
    logic [1:0] irq_id;
    logic [3:0] pending;

    logic       w_intr_en, w_take_intr;
    logic [7:0] w_intr_vector, w_ret_pc;
    logic [1:0] w_irq_id;
    logic [3:0] w_pending;

    logic [7:0] enc_in;
    logic       enc_any;
    logic [2:0] enc_idx;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    intr_ctrl #(.NUM_IRQ(4), .VEC_BASE(8'hE0), .VEC_STRIDE(8'h04)) dut (
        .clock(clock), .reset(reset), .irq(irq), .instr_done(instr_done),
        .pc_in(pc_in), .reti(reti), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .intr_en(intr_en), .take_intr(take_intr), .intr_vector(intr_vector),
        .ret_pc(ret_pc), .irq_id(irq_id), .pending(pending)
    );

    // Same stimulus, vector base near the top of memory to exercise wrap.
    intr_ctrl #(.NUM_IRQ(4), .VEC_BASE(8'hFC), .VEC_STRIDE(8'h04)) dut_wrap (
        .clock(clock), .reset(reset), .irq(irq), .instr_done(instr_done),
        .pc_in(pc_in), .reti(reti), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .intr_en(w_intr_en), .take_intr(w_take_intr), .intr_vector(w_intr_vector),
        .ret_pc(w_ret_pc), .irq_id(w_irq_id), .pending(w_pending)
    );

    intr_prio_enc #(.NUM_IRQ(8), .ID_W(3)) enc (
        .eligible(enc_in), .any(enc_any), .idx(enc_idx)
    );

    typedef struct {
        logic [7:0] eligible;
        logic       any;
        logic [2:0] idx;
    } enc_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq = '0; instr_done = 1'b0; reti = 1'b0; mask_we = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    enc_vec_t enc_tab[8];

    initial begin
        enc_tab[0] = '{8'h00, 1'b0, 3'd0};
        enc_tab[1] = '{8'h01, 1'b1, 3'd0};
        enc_tab[2] = '{8'h80, 1'b1, 3'd7};
        enc_tab[3] = '{8'h0C, 1'b1, 3'd2};
        enc_tab[4] = '{8'hFF, 1'b1, 3'd0};
        enc_tab[5] = '{8'h60, 1'b1, 3'd5};
        enc_tab[6] = '{8'h10, 1'b1, 3'd4};
        enc_tab[7] = '{8'hAA, 1'b1, 3'd1};
        for (int i = 0; i < 8; i++) begin
            enc_in = enc_tab[i].eligible;
            #1;
            check($sformatf("enc_any[%0d]", i), 32'(enc_any), 32'(enc_tab[i].any));
            check($sformatf("enc_idx[%0d]", i), 32'(enc_idx), 32'(enc_tab[i].idx));
        end

        // Reset with all lines high and mask clear.
        reset = 1'b1; irq = 4'b1111;
        tick();
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_intr_en", 32'(intr_en), 32'h0);
        check("rst_vector", 32'(intr_vector), 32'h0);
        reset = 1'b0;
        tick();
        check("edge_pending", 32'(pending), 32'hF);
        check("edge_no_take", 32'(take_intr), 32'h0);
        check("edge_intr_en", 32'(intr_en), 32'h0);
        instr_done = 1'b1;
        tick();
        check("mask0_no_take", 32'(take_intr), 32'h0);
        instr_done = 1'b0;

        // Single masked-in line.
        do_reset();
        write_mask(4'b0100);
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        instr_done = 1'b1; pc_in = 8'h37;
        tick();
        instr_done = 1'b0;
        check("t2_take", 32'(take_intr), 32'h1);
        check("t2_en", 32'(intr_en), 32'h1);
        check("t2_id", 32'(irq_id), 32'h2);
        check("t2_vec", 32'(intr_vector), 32'hE8);
        check("t2_ret", 32'(ret_pc), 32'h37);
        check("t2_pending", 32'(pending), 32'h0);
        check("t2_wrap_vec", 32'(w_intr_vector), 32'h04);
        tick();
        check("t2_take_pulse", 32'(take_intr), 32'h0);
        check("t2_en_hold", 32'(intr_en), 32'h1);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("t2_reti_en", 32'(intr_en), 32'h0);

        // Two simultaneous rises: lowest index first, then the other.
        write_mask(4'b1111);
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        instr_done = 1'b1; pc_in = 8'h11;
        tick();
        instr_done = 1'b0;
        check("t3_take1", 32'(take_intr), 32'h1);
        check("t3_id1", 32'(irq_id), 32'h1);
        check("t3_vec1", 32'(intr_vector), 32'hE4);
        check("t3_pending1", 32'(pending), 32'h8);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("t3_reti_en", 32'(intr_en), 32'h0);
        instr_done = 1'b1; pc_in = 8'h50;
        tick();
        instr_done = 1'b0;
        check("t3_take3", 32'(take_intr), 32'h1);
        check("t3_id3", 32'(irq_id), 32'h3);
        check("t3_vec3", 32'(intr_vector), 32'hEC);
        check("t3_ret3", 32'(ret_pc), 32'h50);

        // No nesting while active; instr_done in the reti cycle does not take.
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        instr_done = 1'b1; pc_in = 8'h60;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_no_take[%0d]", i), 32'(take_intr), 32'h0);
            check($sformatf("t4_pend0[%0d]", i), 32'(pending[0]), 32'h1);
            check($sformatf("t4_ret_hold[%0d]", i), 32'(ret_pc), 32'h50);
        end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("t4_reti_en", 32'(intr_en), 32'h0);
        check("t4_reti_no_take", 32'(take_intr), 32'h0);
        pc_in = 8'h61;
        tick();
        instr_done = 1'b0;
        check("t4_take0", 32'(take_intr), 32'h1);
        check("t4_id0", 32'(irq_id), 32'h0);
        check("t4_vec0", 32'(intr_vector), 32'hE0);
        check("t4_ret0", 32'(ret_pc), 32'h61);
        check("t4_wrap_vec0", 32'(w_intr_vector), 32'hFC);
        reti = 1'b1;
        tick();
        reti = 1'b0;

        // reti while idle.
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("t5_idle_reti_en", 32'(intr_en), 32'h0);
        check("t5_idle_reti_take", 32'(take_intr), 32'h0);
        tick();
        check("t5_idle_stays", 32'(intr_en), 32'h0);

        // Rise on the line being taken in the same cycle: set wins.
        do_reset();
        write_mask(4'b1111);
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        irq = 4'b0010; instr_done = 1'b1; pc_in = 8'h22;
        tick();
        irq = 4'b0000; instr_done = 1'b0;
        check("e1_take", 32'(take_intr), 32'h1);
        check("e1_id", 32'(irq_id), 32'h1);
        check("e1_pending_kept", 32'(pending), 32'h2);
        check("e1_wrap_vec", 32'(w_intr_vector), 32'h00);

        // Mask write in the arbitration cycle is not yet visible.
        reti = 1'b1;
        tick();
        reti = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'b0000; instr_done = 1'b1;
        tick();
        mask_we = 1'b0; instr_done = 1'b0;
        check("e2_old_mask_take", 32'(take_intr), 32'h1);

        // Asynchronous reset while active.
        check("e3_pre_en", 32'(intr_en), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("e3_async_en", 32'(intr_en), 32'h0);
        check("e3_async_pending", 32'(pending), 32'h0);
        check("e3_async_ret", 32'(ret_pc), 32'h0);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
